// File: rtl/ble_ring_drain.sv
// rtl/ble_ring_drain.sv - BLE receive ring buffer drain: Wishbone read master to 8N1 UART transmitter
//
// Purpose:
//   Walks the RAM ring buffer ADR_LL..ADR_UL behind the UART receive writer. It
//   reads one byte per Wishbone cycle and transmits it as 8N1 serial on o_tx.
//   The bus is requested only while i_bus_gnt says the RAM port is free.
//
// Ports:
//   i_wb_clk, i_wb_rst_n   clock, asynchronous active-low reset
//   i_wr_ptr               writer's next-write address; reading stops when rd_ptr reaches it
//   i_flush                pulse, discard unread data (deferred to IDLE if a frame is in flight)
//   i_bus_gnt              RAM port free for this block (sampled in IDLE only)
//   o_wb_*/i_wb_*          Wishbone read master; only i_wb_rdt[7:0] is used
//   o_tx                   serial out, idle high
//   o_busy                 high outside IDLE
//   o_rd_ptr               current read pointer
//   o_err                  sticky ack-timeout flag, cleared only by reset
module ble_ring_drain #(
    parameter logic [31:0] ADR_LL       = 32'h00C00000,
    parameter logic [31:0] ADR_UL       = 32'h00C10000,
    parameter logic [31:0] STRIDE       = 32'd2,
    parameter int          CLKS_PER_BIT = 104,
    parameter int          ACK_TIMEOUT  = 15
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic [31:0] i_wr_ptr,
    input  logic        i_flush,
    input  logic        i_bus_gnt,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_tx,
    output logic        o_busy,
    output logic [31:0] o_rd_ptr,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // One counter serves both as the baud divider and as the ack-timeout timer,
    // since the two are never needed in the same state.
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [15:0] r_baud, w_baud_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic        r_err, w_err_nxt;
    logic        r_flush_pend, w_flush_pend_nxt;
    logic [31:0] w_rd_ptr_sum;
    logic [31:0] w_rd_ptr_inc;
    logic        w_baud_done;
    logic        w_unused;

    // Same wrap compare as the writer, so both pointers land on ADR_LL together.
    assign w_rd_ptr_sum = r_rd_ptr + STRIDE;
    assign w_rd_ptr_inc = (w_rd_ptr_sum > ADR_UL) ? ADR_LL : w_rd_ptr_sum;
    assign w_baud_done  = (r_baud == BAUD_LAST);
    assign w_unused     = &{1'b0, i_wb_rdt[31:8]};

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state      <= S_IDLE;
            r_rd_ptr     <= ADR_LL;
            r_shift      <= 8'h00;
            r_baud       <= 16'd0;
            r_bit        <= 3'd0;
            r_err        <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_shift      <= w_shift_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_err        <= w_err_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_shift_nxt      = r_shift;
        w_baud_nxt       = r_baud;
        w_bit_nxt        = r_bit;
        w_err_nxt        = r_err;
        w_flush_pend_nxt = r_flush_pend;
        o_tx             = 1'b1;

        // A flush seen mid-frame waits for IDLE so the frame on the wire is never cut.
        if (r_state != S_IDLE && i_flush) begin
            w_flush_pend_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_flush || r_flush_pend) begin
                    w_rd_ptr_nxt     = i_wr_ptr;
                    w_flush_pend_nxt = 1'b0;
                end else if (r_rd_ptr != i_wr_ptr && i_bus_gnt) begin
                    w_state_nxt = S_REQ;
                    w_baud_nxt  = 16'd0;
                end
            end
            S_REQ: begin
                if (i_wb_ack) begin
                    w_shift_nxt  = i_wb_rdt[7:0];
                    w_rd_ptr_nxt = w_rd_ptr_inc;
                    w_baud_nxt   = 16'd0;
                    w_state_nxt  = S_START;
                end else if (r_baud == ACK_LAST) begin
                    // Pointer is left alone so the same byte is retried.
                    w_err_nxt   = 1'b1;
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_START: begin
                o_tx = 1'b0;
                if (w_baud_done) begin
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                o_tx = r_shift[0];
                if (w_baud_done) begin
                    w_baud_nxt  = 16'd0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt  = 16'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_wb_adr = r_rd_ptr;
    assign o_wb_cyc = (r_state == S_REQ);
    assign o_wb_we  = 1'b0;
    assign o_wb_sel = 4'b0001;
    assign o_busy   = (r_state != S_IDLE);
    assign o_rd_ptr = r_rd_ptr;
    assign o_err    = r_err;

endmodule
